// File: rtl/tick_sched_ctrl.sv
// Tick scheduler: free-running us/ms prescalers plus a STOP/RUN/HOLD controlled
// millisecond phase counter that produces the second strobe and set-mode blink.
module tick_sched_ctrl #(
  parameter int CLK_PER_US = 50,
  parameter int US_PER_MS  = 1000,
  parameter int MS_PER_S   = 1000
) (
  input  logic                          clk_50mhz,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          stop,
  input  logic                          fast,
  output logic                          tick_1us,
  output logic                          tick_1ms,
  output logic                          tick_1s,
  output logic                          blink,
  output logic [1:0]                    state,
  output logic [$clog2(MS_PER_S)-1:0]   ms_cnt
);

  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int US_W  = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
  localparam int MS_W  = $clog2(MS_PER_S);

  localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(CLK_PER_US - 1);
  localparam logic [PRE_W-1:0] PRE_ONE      = PRE_W'(1);
  localparam logic [US_W-1:0]  US_LAST      = US_W'(US_PER_MS - 1);
  localparam logic [US_W-1:0]  US_ONE       = US_W'(1);
  localparam logic [MS_W-1:0]  MS_LAST      = MS_W'(MS_PER_S - 1);
  localparam logic [MS_W-1:0]  MS_LAST_FAST = MS_W'(MS_PER_S / 8 - 1);
  localparam logic [MS_W-1:0]  MS_ONE       = MS_W'(1);

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t            state_r;
  state_t            nxt_state_s;
  logic [PRE_W-1:0]  pre_cnt;
  logic [US_W-1:0]   us_cnt;
  logic [MS_W-1:0]   terminal_s;
  logic [MS_W-1:0]   nxt_ms_s;
  logic              nxt_tick_1s_s;

  // Free-running prescalers; they never stop so the display scan keeps going.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      us_cnt   <= '0;
      tick_1us <= 1'b0;
      tick_1ms <= 1'b0;
    end else begin
      pre_cnt  <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_ONE;
      tick_1us <= (pre_cnt == PRE_LAST);
      tick_1ms <= tick_1us && (us_cnt == US_LAST);
      if (tick_1us) begin
        us_cnt <= (us_cnt == US_LAST) ? '0 : us_cnt + US_ONE;
      end else begin
        us_cnt <= us_cnt;
      end
    end
  end

  // Control FSM: stop dominates, then pause (RUN only), then start.
  always_comb begin
    nxt_state_s = state_r;
    if (stop) begin
      nxt_state_s = ST_STOP;
    end else begin
      case (state_r)
        ST_STOP: nxt_state_s = start ? ST_RUN : ST_STOP;
        ST_RUN:  nxt_state_s = pause ? ST_HOLD : ST_RUN;
        ST_HOLD: nxt_state_s = start ? ST_RUN : ST_HOLD;
        default: nxt_state_s = ST_STOP;
      endcase
    end
  end

  assign terminal_s = fast ? MS_LAST_FAST : MS_LAST;

  // Millisecond phase; a wrap coinciding with stop is swallowed by the clear.
  always_comb begin
    nxt_ms_s      = ms_cnt;
    nxt_tick_1s_s = 1'b0;
    if (stop || (state_r == ST_STOP)) begin
      nxt_ms_s = '0;
    end else if ((state_r == ST_RUN) && tick_1ms) begin
      if (ms_cnt >= terminal_s) begin
        nxt_ms_s      = '0;
        nxt_tick_1s_s = 1'b1;
      end else begin
        nxt_ms_s = ms_cnt + MS_ONE;
      end
    end else begin
      nxt_ms_s = ms_cnt;
    end
  end

  // State, phase and second-strobe registers.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      state_r <= ST_STOP;
      ms_cnt  <= '0;
      tick_1s <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      ms_cnt  <= nxt_ms_s;
      tick_1s <= nxt_tick_1s_s;
    end
  end

  assign state = state_r;

  // Blink is a pure decode of registered phase; steady on outside RUN.
  always_comb begin
    blink = 1'b1;
    if (state_r == ST_RUN) begin
      blink = (ms_cnt < ((terminal_s >> 1) + MS_ONE));
    end else begin
      blink = 1'b1;
    end
  end

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Randomized bench for tick_sched_ctrl against an edge-count based reference model.
module tb_tick_sched_ctrl;

  localparam int CPU  = 5;
  localparam int UPM  = 4;
  localparam int MPS  = 8;
  localparam int MS_W = $clog2(MPS);

  logic            clk_50mhz = 1'b0;
  logic            rst_n     = 1'b0;
  logic            start     = 1'b0;
  logic            pause     = 1'b0;
  logic            stop      = 1'b0;
  logic            fast      = 1'b0;
  logic            tick_1us;
  logic            tick_1ms;
  logic            tick_1s;
  logic            blink;
  logic [1:0]      state;
  logic [MS_W-1:0] ms_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: k = edges since the last reset edge; state 0 STOP, 1 RUN, 2 HOLD.
  int k       = 0;
  int m_state = 0;
  int m_ms    = 0;
  bit m_t1s   = 1'b0;
  int n_t1s   = 0;

  always #10 clk_50mhz = ~clk_50mhz;

  tick_sched_ctrl #(
    .CLK_PER_US (CPU),
    .US_PER_MS  (UPM),
    .MS_PER_S   (MPS)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .fast      (fast),
    .tick_1us  (tick_1us),
    .tick_1ms  (tick_1ms),
    .tick_1s   (tick_1s),
    .blink     (blink),
    .state     (state),
    .ms_cnt    (ms_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  function automatic int term_of(input bit f);
    return f ? (MPS / 8 - 1) : (MPS - 1);
  endfunction

  function automatic bit exp_1us(input int kk);
    return (kk > 0) && (kk % CPU == 0);
  endfunction

  function automatic bit exp_1ms(input int kk);
    return (kk >= CPU * UPM + 1) && ((kk - 1) % (CPU * UPM) == 0);
  endfunction

  task automatic model_edge();
    bit t1ms;
    t1ms = exp_1ms(k);
    if (!rst_n) begin
      k       = 0;
      m_state = 0;
      m_ms    = 0;
      m_t1s   = 1'b0;
    end else begin
      k++;
      m_t1s = 1'b0;
      if (stop) begin
        m_state = 0;
        m_ms    = 0;
      end else begin
        if (m_state == 1 && t1ms) begin
          if (m_ms >= term_of(fast)) begin
            m_ms  = 0;
            m_t1s = 1'b1;
          end else begin
            m_ms++;
          end
        end
        if (m_state == 0 && start)      m_state = 1;
        else if (m_state == 1 && pause) m_state = 2;
        else if (m_state == 2 && start) m_state = 1;
      end
    end
  endtask

  task automatic cycle();
    bit exp_blink;
    @(posedge clk_50mhz);
    model_edge();
    @(negedge clk_50mhz);
    if (m_t1s) n_t1s++;
    exp_blink = (m_state == 1) ? (m_ms < term_of(fast) / 2 + 1) : 1'b1;
    check_val("tick_1us", {31'd0, tick_1us}, {31'd0, exp_1us(k)});
    check_val("tick_1ms", {31'd0, tick_1ms}, {31'd0, exp_1ms(k)});
    check_val("tick_1s",  {31'd0, tick_1s},  {31'd0, m_t1s});
    check_val("state",    {30'd0, state},    32'(m_state));
    check_val("ms_cnt",   32'(ms_cnt),       32'(m_ms));
    check_val("blink",    {31'd0, blink},    {31'd0, exp_blink});
  endtask

  initial begin
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (100) cycle();

    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (200) cycle();

    fast = 1'b1;
    repeat (100) cycle();
    fast = 1'b0;

    for (int i = 0; i < 6000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 59) == 0);
      stop  = ($urandom_range(0, 199) == 0);
      if (exp_1ms(k)) begin
        if ($urandom_range(0, 5) == 0) stop  = 1'b1;
        if ($urandom_range(0, 5) == 0) pause = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        start = 1'b1;
        pause = 1'b1;
        stop  = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) fast = ~fast;
      rst_n = ($urandom_range(0, 799) != 0);
      cycle();
    end

    check_val("saw_tick_1s", {31'd0, (n_t1s > 0)}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
